// File: rtl/jtcop_obj_pkg.sv
// Shared definitions for the object line buffer: FSM states, erase value
// and the width of a {bank, column} address.
package jtcop_obj_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } obj_state_t;

  // One bank bit plus a 9-bit column
  localparam int BANK_AW = 10;

  // Value left behind by the erase and power-up clear passes
  localparam logic [7:0] CLR_VAL = 8'h00;

endpackage

// File: rtl/jtframe_dual_ram.sv
// Dual-port RAM, single clock. Port 0 is write-only; port 1 writes and
// reads, and its read register only updates when rd1 is high, so the last
// read value is held through the erase cycle that follows it.
module jtframe_dual_ram #(
  parameter int aw = 10,
  parameter int dw = 8
)(
  input  logic          clk,
  // port 0: write only
  input  logic [dw-1:0] data0,
  input  logic [aw-1:0] addr0,
  input  logic          we0,
  // port 1: read / write
  input  logic [dw-1:0] data1,
  input  logic [aw-1:0] addr1,
  input  logic          we1,
  input  logic          rd1,
  output logic [dw-1:0] q1
);

  logic [dw-1:0] mem [0:(2**aw)-1];

  // Both write ports and the registered port-1 read
  always_ff @(posedge clk) begin
    if (we0) mem[addr0] <= data0;
    if (we1) mem[addr1] <= data1;
    if (rd1) q1 <= mem[addr1];
  end

endmodule

// File: rtl/jtcop_obj_buffer.sv
// Double-buffered object line buffer. The renderer writes into draw_bank,
// the video side reads the other bank and erases each visible pixel right
// after reading it. A clear pass over both banks runs after every reset.
module jtcop_obj_buffer
  import jtcop_obj_pkg::*;
#(
  parameter int         HFLIP_W = BANK_AW - 1,
  parameter logic [7:0] CLR_VAL = jtcop_obj_pkg::CLR_VAL
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               pxl_cen,
  input  logic               LHBL,
  input  logic [HFLIP_W-1:0] hdump,
  input  logic               flip,
  input  logic [HFLIP_W-1:0] buf_addr,
  input  logic [7:0]         buf_data,
  input  logic               buf_we,
  output logic [7:0]         obj_pxl,
  output logic               draw_bank,
  output logic               ready
);

  localparam int AW = HFLIP_W + 1;

  obj_state_t    state_reg, state_next;
  logic [AW-1:0] clr_addr_reg;
  logic          draw_bank_reg;
  logic          lhbl_last_reg;
  logic [AW-1:0] erase_addr_reg;
  logic          erase_pend_reg;
  logic [7:0]    obj_pxl_reg;

  logic          swap;
  logic [AW-1:0] rd_addr;
  logic          we_a;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic [7:0]    data_b;
  logic          we_b;
  logic          rd_b;
  logic [7:0]    q_b;

  // Falling edge of LHBL, only meaningful once the clear pass is done
  assign swap    = (state_reg == ST_RUN) && lhbl_last_reg && !LHBL;
  assign rd_addr = {~draw_bank_reg, flip ? ~hdump : hdump};

  // Renderer port: transparent pixels (colour index 0) are dropped.
  // Uses the current draw_bank, so a write in the swap cycle lands in the
  // old bank.
  assign we_a   = (state_reg == ST_RUN) && buf_we && (buf_data[3:0] != 4'd0);
  assign addr_a = {draw_bank_reg, buf_addr};

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_INIT;
    else     state_reg <= state_next;
  end

  // FSM next state: leave INIT after the last address; never come back
  always_comb begin
    state_next = state_reg;
    if (state_reg == ST_INIT && clr_addr_reg == {AW{1'b1}})
      state_next = ST_RUN;
  end

  // FSM outputs: port B mux between clear pass, erase and video read.
  // The erase uses the latched address, so a swap in between cannot
  // redirect it to the other bank.
  always_comb begin
    addr_b = rd_addr;
    data_b = CLR_VAL;
    we_b   = 1'b0;
    rd_b   = 1'b0;
    case (state_reg)
      ST_INIT: begin
        addr_b = clr_addr_reg;
        we_b   = 1'b1;
      end
      default: begin
        if (erase_pend_reg) begin
          addr_b = erase_addr_reg;
          we_b   = 1'b1;
        end else if (pxl_cen) begin
          rd_b   = 1'b1;
        end
      end
    endcase
  end

  // Clear-pass address counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      clr_addr_reg <= '0;
    else if (state_reg == ST_INIT) clr_addr_reg <= clr_addr_reg + 1'b1;
  end

  // LHBL history and bank toggle on its falling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lhbl_last_reg <= 1'b0;
      draw_bank_reg <= 1'b0;
    end else begin
      lhbl_last_reg <= LHBL;
      if (swap) draw_bank_reg <= ~draw_bank_reg;
    end
  end

  // Erase latch: remember each read address, erase it next cycle unless
  // the read happened during blanking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      erase_addr_reg <= '0;
      erase_pend_reg <= 1'b0;
    end else begin
      erase_pend_reg <= rd_b && LHBL;
      if (rd_b) erase_addr_reg <= addr_b;
    end
  end

  // Output register: second pipeline stage, blanked outside active video
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                obj_pxl_reg <= 8'h00;
    else if (state_reg != ST_RUN || !LHBL)  obj_pxl_reg <= 8'h00;
    else if (pxl_cen)                       obj_pxl_reg <= q_b;
  end

  jtframe_dual_ram #(
    .aw (AW),
    .dw (8)
  ) u_ram (
    .clk   (clk),
    .data0 (buf_data),
    .addr0 (addr_a),
    .we0   (we_a),
    .data1 (data_b),
    .addr1 (addr_b),
    .we1   (we_b),
    .rd1   (rd_b),
    .q1    (q_b)
  );

  assign obj_pxl   = obj_pxl_reg;
  assign draw_bank = draw_bank_reg;
  assign ready     = (state_reg == ST_RUN);

endmodule

// File: tb/tb_jtcop_obj_buffer.sv
// Self-checking bench for jtcop_obj_buffer against a bank-array model.
module tb_jtcop_obj_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pxl_cen = 1'b0;
  logic       LHBL = 1'b1;
  logic [8:0] hdump = '0;
  logic       flip = 1'b0;
  logic [8:0] buf_addr = '0;
  logic [7:0] buf_data = '0;
  logic       buf_we = 1'b0;
  logic [7:0] obj_pxl;
  logic       draw_bank;
  logic       ready;

  jtcop_obj_buffer u_dut (
    .clk       (clk),
    .rst       (rst),
    .pxl_cen   (pxl_cen),
    .LHBL      (LHBL),
    .hdump     (hdump),
    .flip      (flip),
    .buf_addr  (buf_addr),
    .buf_data  (buf_data),
    .buf_we    (buf_we),
    .obj_pxl   (obj_pxl),
    .draw_bank (draw_bank),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  // Reference model: two banks of 512 pixels, the renderer bank index and
  // the value most recently fetched by a video read
  logic [7:0] mdl [2][512];
  int         db;
  logic [7:0] pending;
  bit         pending_ok;
  bit         mdl_run;
  bit         rnd_wr;
  logic [7:0] last_obj;

  int errors_cnt = 0;
  int checks_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mdl_reset;
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < 512; c++) mdl[b][c] = 8'h00;
    db = 0;
    pending = 8'h00;
    pending_ok = 0;
    mdl_run = 0;
  endtask

  task automatic mdl_write(input int a, input logic [7:0] d);
    if (mdl_run && d[3:0] != 4'd0) mdl[db][a & 511] = d;
  endtask

  task automatic write_px(input int a, input logic [7:0] d);
    buf_addr = a[8:0];
    buf_data = d;
    buf_we   = 1'b1;
    mdl_write(a, d);
    tick;
    buf_we = 1'b0;
    $display("write col=%0d data=%02h bank=%0d", a, d, db);
  endtask

  // One video pixel: pxl_cen cycle, then a free cycle (erase slot)
  task automatic pxl(input int h);
    int         col;
    logic [7:0] exp_v;
    bit         do_chk;
    logic [7:0] rd;
    col    = flip ? ((~h) & 511) : (h & 511);
    exp_v  = LHBL ? pending : 8'h00;
    do_chk = pending_ok || !LHBL;
    pending = mdl[db ^ 1][col];
    pending_ok = 1;
    if (LHBL) mdl[db ^ 1][col] = 8'h00;
    hdump   = h[8:0];
    pxl_cen = 1'b1;
    tick;
    pxl_cen  = 1'b0;
    last_obj = obj_pxl;
    if (do_chk) check_val("pxl", obj_pxl, exp_v);
    if (rnd_wr && ($urandom % 4 == 0)) begin
      rd = 8'($urandom);
      buf_addr = 9'($urandom);
      buf_data = rd;
      buf_we   = 1'b1;
      mdl_write(int'(buf_addr), rd);
    end
    tick;
    buf_we = 1'b0;
  endtask

  // Line end: LHBL falls (optionally with a renderer write in that very
  // cycle), blanking reads of columns 0..15, LHBL rises
  task automatic swap_line(input bit wr, input int a, input logic [7:0] d);
    LHBL = 1'b0;
    if (wr) begin
      buf_addr = a[8:0];
      buf_data = d;
      buf_we   = 1'b1;
      mdl_write(a, d);
    end
    tick;
    buf_we = 1'b0;
    db ^= 1;
    check_val("draw_bank", {31'd0, draw_bank}, db);
    check_val("blank_obj", {24'd0, obj_pxl}, 32'd0);
    for (int c = 0; c < 16; c++) pxl(c);
    LHBL = 1'b1;
    tick;
    $display("swap draw_bank=%0d", db);
  endtask

  task automatic sweep(input int lo, input int hi, input logic [7:0] target,
                       output int hits, output int hit_col, output int nz);
    int prev_h;
    hits = 0;
    hit_col = -1;
    nz = 0;
    prev_h = -1;
    for (int h = lo; h <= hi; h++) begin
      pxl(h);
      if (last_obj == target) begin
        hits++;
        hit_col = prev_h;
      end
      if (last_obj != 8'h00) nz++;
      prev_h = h;
    end
    $display("sweep %0d..%0d flip=%0d hits=%0d read_col=%0d nonzero=%0d", lo, hi, flip, hits, hit_col, nz);
  endtask

  // Release reset and walk the clear pass, checking ready timing, then
  // confirm both banks are blank through the RAM array
  task automatic init_pass;
    int nz;
    tick;
    rst = 1'b0;
    for (int i = 1; i <= 1024; i++) begin
      if (i == 500) begin
        buf_addr = 9'd5;
        buf_data = 8'hff;
        buf_we   = 1'b1;
      end
      tick;
      buf_we = 1'b0;
      if (i == 1) begin
        check_val("init_obj", {24'd0, obj_pxl}, 32'd0);
        check_val("init_ready", {31'd0, ready}, 32'd0);
      end
      if (i == 1023) check_val("ready_1023", {31'd0, ready}, 32'd0);
      if (i == 1024) check_val("ready_1024", {31'd0, ready}, 32'd1);
    end
    mdl_run = 1;
    nz = 0;
    for (int i = 0; i < 1024; i++)
      if (u_dut.u_ram.mem[i] != 8'h00) nz++;
    check_val("dump_blank", nz, 32'd0);
    $display("init done ready=%0d nonzero_cells=%0d", ready, nz);
  endtask

  int hits, hit_col, nz;

  initial begin
    mdl_reset();
    rnd_wr = 0;
    tick;
    check_val("rst_obj", {24'd0, obj_pxl}, 32'd0);
    check_val("rst_bank", {31'd0, draw_bank}, 32'd0);
    check_val("rst_ready", {31'd0, ready}, 32'd0);
    init_pass();

    // Single pixel drawn at column 10, also read once during blanking
    write_px(10, 8'h35);
    swap_line(0, 0, 8'h00);
    sweep(0, 319, 8'h35, hits, hit_col, nz);
    check_val("line_hits", hits, 32'd1);
    check_val("line_col", hit_col, 32'd10);

    // Transparency and last-write-wins
    write_px(5, 8'h40);
    write_px(5, 8'h27);
    write_px(5, 8'h30);
    swap_line(0, 0, 8'h00);
    sweep(0, 15, 8'h27, hits, hit_col, nz);
    check_val("ovr_hits", hits, 32'd1);
    check_val("ovr_col", hit_col, 32'd5);

    // Second pass over the same line after erase
    sweep(0, 15, 8'h27, hits, hit_col, nz);
    check_val("erase_nz", nz, 32'd0);

    // Flip: column 3 is read when hdump is 508
    write_px(3, 8'h5a);
    flip = 1'b1;
    swap_line(0, 0, 8'h00);
    sweep(500, 511, 8'h5a, hits, hit_col, nz);
    check_val("flip_hits", hits, 32'd1);
    check_val("flip_col", hit_col, 32'd508);
    flip = 1'b0;

    // Renderer write in the swap cycle goes to the old draw bank
    swap_line(1, 20, 8'h61);
    sweep(0, 31, 8'h61, hits, hit_col, nz);
    check_val("swapwr_hits", hits, 32'd1);
    check_val("swapwr_col", hit_col, 32'd20);

    // Random lines with writes interleaved with video reads
    rnd_wr = 1;
    for (int ln = 0; ln < 6; ln++) begin
      for (int k = 0; k < 20; k++) write_px(int'($urandom_range(0, 511)), 8'($urandom));
      flip = 1'($urandom);
      swap_line(1'($urandom), int'($urandom_range(0, 511)), 8'($urandom));
      sweep(0, 511, 8'h00, hits, hit_col, nz);
    end
    rnd_wr = 0;
    flip = 1'b0;

    // Asynchronous reset in the middle of a visible line
    write_px(7, 8'h7c);
    swap_line(0, 0, 8'h00);
    sweep(0, 8, 8'h7c, hits, hit_col, nz);
    check_val("prerst_obj", {24'd0, obj_pxl}, 32'h7c);
    #3;
    rst = 1'b1;
    #1;
    check_val("arst_obj", {24'd0, obj_pxl}, 32'd0);
    check_val("arst_ready", {31'd0, ready}, 32'd0);
    check_val("arst_bank", {31'd0, draw_bank}, 32'd0);
    $display("async reset asserted obj_pxl=%02h ready=%0d", obj_pxl, ready);
    mdl_reset();
    tick;
    tick;
    init_pass();

    // Buffer still works after the second clear pass
    write_px(100, 8'h19);
    swap_line(0, 0, 8'h00);
    sweep(90, 110, 8'h19, hits, hit_col, nz);
    check_val("post_hits", hits, 32'd1);
    check_val("post_col", hit_col, 32'd100);

    $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
    $finish;
  end

endmodule

// File: doc/jtcop_obj_buffer.md
# jtcop_obj_buffer

Double-buffered object line buffer between the sprite renderer and the colour mixer. The renderer draws one scan line into the back bank while the video side reads the front bank pixel by pixel, producing the 8-bit `obj_pxl` consumed by the colour mixer. Each pixel is erased right after it is read, so a bank is blank when it becomes the next draw bank. A power-up clear pass guarantees both banks start blank.

## Interface
Parameters:
- `HFLIP_W`, default 9: width of the horizontal pixel address (512 positions per bank).
- `CLR_VAL`, default 8'h00: value written by the erase and init passes.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  reset, asynchronous and active-high.
- `pxl_cen`  in  1  pixel clock enable; at most one pulse every 2 `clk` cycles.
- `LHBL`  in  1  horizontal blank, active low; the falling edge swaps banks.
- `hdump`  in  9  current video pixel column.
- `flip`  in  1  screen flip; read address becomes `~hdump`.
- `buf_addr`  in  9  renderer pixel column.
- `buf_data`  in  8  renderer pixel: bits 7:4 are the palette/priority field, bits 3:0 are the colour index.
- `buf_we`  in  1  renderer write strobe, sampled every `clk`.
- `obj_pxl`  out  8  pixel to the colour mixer.
- `draw_bank`  out  1  bank currently written by the renderer.
- `ready`  out  1  high once the init clear is complete.

## Operation
- Storage is 2 × 512 × 8. The address is `{bank, column}`.
  - Port A: renderer writes, always to `draw_bank`.
  - Port B: video read/erase, always to `~draw_bank`.
- Transparency: a write with `buf_data[3:0]==0` is discarded. A non-zero pixel overwrites whatever is stored, so the last write wins.
- FSM states:
  - INIT, entered on reset: port B walks addresses 0..1023, one per `clk`, writing `CLR_VAL`. In this state `buf_we` is ignored, `obj_pxl`=0 and `ready`=0. After address 1023 the FSM moves to RUN and `ready`=1.
  - RUN, read phase: on a `pxl_cen` cycle, port B reads address `{~draw_bank, flip ? ~hdump : hdump}`.
  - RUN, erase phase: on the next `clk` cycle, port B writes `CLR_VAL` to the same address, but only if LHBL was high at the read. No erase happens during blanking.
  - The FSM never returns to INIT except through `rst`.
- Bank swap: `draw_bank` toggles on the `clk` cycle in which LHBL is sampled going 1→0, in RUN only. This happens at every line regardless of LVBL.
- Output: `obj_pxl` is registered from the port B read data. It is forced to 0 while LHBL is low.

## Timing
- Reset values: `obj_pxl`=0, `draw_bank`=0, `ready`=0, FSM=INIT, clear address=0.
- Init duration: 1024 `clk` cycles after `rst` falls. `ready` rises on cycle 1024.
- Read latency: the pixel addressed at `pxl_cen` edge N appears on `obj_pxl` after `pxl_cen` edge N+1 (2-stage: RAM read, then output register). The colour mixer's blank delay accounts for this.
- Renderer write: one `clk` to commit. A read of the draw bank is never possible, so there is no read-during-write hazard.
- Simultaneous events:
  - Renderer write and bank swap in the same cycle: the write goes to the old `draw_bank`.
  - Erase cycle coinciding with a swap: the erase targets the pre-swap read bank, using the latched address including its bank bit.
- `rst` mid-line or mid-init: the FSM restarts INIT at address 0, and bank contents are re-cleared.
- Wrap-around: `hdump` and `buf_addr` are used modulo 512. There are no out-of-range writes.

## Structure
- Shared package `jtcop_obj_pkg`: FSM state constants (`ST_INIT`, `ST_RUN`), `CLR_VAL`, bank address width (10).
- Sub-module: `jtframe_dual_ram`, with `aw`=10 and `dw`=8.
  - Port A: renderer.
  - Port B: FSM-muxed address/data/we (init clear, video read, erase).
- The FSM, swap-edge detector, erase latch and output register are in the top module.

## Test plan
- Reset release -> `ready` low for 1024 clk and `obj_pxl`=0. Then dump both banks via backdoor: all 0.
- Draw line: write 8'h35 at column 10, then toggle LHBL low→high, then sweep `hdump` 0..319 -> `obj_pxl`=8'h35 exactly once, 2 `pxl_cen` after `hdump`=10; 0 elsewhere.
- Transparency/overwrite: write 8'h40 then 8'h27 then 8'h30 at column 5 -> readback is 8'h27.
- Erase: read the same line twice without drawing -> second pass is all 0; a read during LHBL low leaves the data intact.
- Flip: `flip`=1 with a pixel at column 3 -> output appears when `hdump`=508.
- Async reset asserted mid-RUN with the banks holding data -> `obj_pxl`=0 immediately, the INIT pass repeats, and the banks are cleared.
